can_rec_arbiter: RTL and testbench

- Shares the single CAN receive/processing path of mopshubCore among N_BUS CAN buses.
- Watches per-bus receive interrupts and picks one bus with round-robin fairness.
- Drives the receive bus select, then holds the grant until the core signals end_can_proc or a watchdog expires.
- Sits between the per-bus CAN controllers' irq lines and the core's can_rec_select / end_can_proc handshake.

---
 rtl/can_rec_arbiter.sv | 157 +++++++++++++++
 tb/tb_can_rec_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/can_rec_arbiter.sv
// can_rec_arbiter: shares the single CAN receive/processing path of the core
// among N_BUS CAN buses. Pending receive interrupts (masked by bus_mask) are
// arbitrated round-robin starting after the last serviced bus. The winning
// index is driven on can_rec_select and held until the core reports
// end_can_proc or the watchdog expires. A one-cycle RELEASE gap gives the
// serviced bus time to drop its interrupt before the next arbitration.
// All outputs are registered; timeout_err and the grant_cnt increment become
// visible in the RELEASE cycle that follows the deciding WAIT_DONE cycle.
module can_rec_arbiter #(
    parameter int N_BUS   = 32,
    parameter int SEL_W   = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BUS-1:0]  irq_can_rec,
    input  logic [N_BUS-1:0]  bus_mask,
    input  logic              tra_busy,
    input  logic              end_can_proc,
    output logic [SEL_W-1:0]  can_rec_select,
    output logic              start_rec,
    output logic              rec_busy,
    output logic              timeout_err,
    output logic [SEL_W-1:0]  err_bus,
    output logic [15:0]       grant_cnt
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [SEL_W-1:0]    err_bus_q, err_bus_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                tmo_q, tmo_d;

    logic [N_BUS-1:0]    req_s;
    logic [SEL_W-1:0]    pick_s;

    // Round-robin search: first set request bit after 'last', wrapping at N_BUS.
    // Indices >= N_BUS are unreachable because the search is taken modulo N_BUS.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_BUS-1:0] req,
                                                 input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] pick;
        logic [N_BUS-1:0] rot;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int off = 1; off <= N_BUS; off++) begin
            idx = (int'(last) + off) % N_BUS;
            rot = req >> idx;
            if (!found && rot[0]) begin
                pick  = SEL_W'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    assign req_s  = irq_can_rec & bus_mask;
    assign pick_s = rr_pick(req_s, last_q);

    // Next-state and registered-output decode for the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        err_bus_d = err_bus_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        start_d   = 1'b0;
        tmo_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((req_s != '0) && !tra_busy) begin
                    sel_d   = pick_s;
                    start_d = 1'b1;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                timer_d = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                timer_d = timer_q + TMR_W'(1);
                if (end_can_proc) begin
                    // Completion wins over a simultaneous watchdog expiry.
                    cnt_d   = cnt_q + 16'd1;
                    state_d = RELEASE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    tmo_d     = 1'b1;
                    err_bus_d = sel_q;
                    state_d   = RELEASE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            RELEASE: begin
                last_d  = sel_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_q    <= SEL_W'(N_BUS - 1);
            err_bus_q <= '0;
            cnt_q     <= 16'd0;
            timer_q   <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            err_bus_q <= err_bus_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            tmo_q     <= tmo_d;
        end
    end

    assign can_rec_select = sel_q;
    assign start_rec      = start_q;
    assign rec_busy       = busy_q;
    assign timeout_err    = tmo_q;
    assign err_bus        = err_bus_q;
    assign grant_cnt      = cnt_q;

endmodule

// File: tb/tb_can_rec_arbiter.sv
// Directed bench for can_rec_arbiter with TIMEOUT=16. Inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_can_rec_arbiter;

    localparam int N_BUS   = 32;
    localparam int SEL_W   = 5;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_BUS-1:0]  irq_can_rec;
    logic [N_BUS-1:0]  bus_mask;
    logic              tra_busy;
    logic              end_can_proc;
    logic [SEL_W-1:0]  can_rec_select;
    logic              start_rec;
    logic              rec_busy;
    logic              timeout_err;
    logic [SEL_W-1:0]  err_bus;
    logic [15:0]       grant_cnt;

    int checks = 0;
    int errors = 0;

    can_rec_arbiter #(.N_BUS(N_BUS), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_can_rec    (irq_can_rec),
        .bus_mask       (bus_mask),
        .tra_busy       (tra_busy),
        .end_can_proc   (end_can_proc),
        .can_rec_select (can_rec_select),
        .start_rec      (start_rec),
        .rec_busy       (rec_busy),
        .timeout_err    (timeout_err),
        .err_bus        (err_bus),
        .grant_cnt      (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full service: grant observed, then completed by end_can_proc.
    task automatic serve(input int bus);
        tick();
        check("rr_sel", 32'(can_rec_select), 32'(bus));
        check("rr_start", 32'(start_rec), 32'd1);
        tick();
        end_can_proc = 1'b1;
        tick();
        end_can_proc = 1'b0;
        tick();
    endtask

    initial begin
        rst          = 1'b0;
        irq_can_rec  = '0;
        bus_mask     = '1;
        tra_busy     = 1'b0;
        end_can_proc = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_sel", 32'(can_rec_select), 32'd0);
        check("rst_start", 32'(start_rec), 32'd0);
        check("rst_busy", 32'(rec_busy), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        check("rst_errbus", 32'(err_bus), 32'd0);
        check("rst_cnt", 32'(grant_cnt), 32'd0);
        rst = 1'b1;
        tick();

        // Single request on bus 3
        irq_can_rec[3] = 1'b1;
        tick();
        check("single_sel", 32'(can_rec_select), 32'd3);
        check("single_start", 32'(start_rec), 32'd1);
        check("single_busy", 32'(rec_busy), 32'd1);
        tick();
        check("single_start_pulse", 32'(start_rec), 32'd0);
        tick();
        tick();
        tick();
        check("single_wait_busy", 32'(rec_busy), 32'd1);
        end_can_proc = 1'b1;
        tick();
        end_can_proc = 1'b0;
        irq_can_rec[3] = 1'b0;
        check("single_release_busy", 32'(rec_busy), 32'd1);
        check("single_cnt", 32'(grant_cnt), 32'd1);
        tick();
        check("single_idle_busy", 32'(rec_busy), 32'd0);
        check("single_hold_sel", 32'(can_rec_select), 32'd3);

        // end_can_proc outside WAIT_DONE is ignored
        end_can_proc = 1'b1;
        tick();
        end_can_proc = 1'b0;
        check("stray_end_cnt", 32'(grant_cnt), 32'd1);

        // Round-robin from a fresh reset: 0, 5, 31, 0
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        irq_can_rec[0]  = 1'b1;
        irq_can_rec[5]  = 1'b1;
        irq_can_rec[31] = 1'b1;
        serve(0);
        serve(5);
        serve(31);
        serve(0);
        check("rr_cnt", 32'(grant_cnt), 32'd4);
        irq_can_rec = '0;
        tick();

        // Mask and tra_busy hold-off on bus 7
        bus_mask       = '1;
        bus_mask[7]    = 1'b0;
        irq_can_rec[7] = 1'b1;
        tick();
        tick();
        check("mask_nogrant", 32'(rec_busy), 32'd0);
        tra_busy = 1'b1;
        bus_mask = '1;
        tick();
        tick();
        check("trabusy_nogrant", 32'(rec_busy), 32'd0);
        check("trabusy_nostart", 32'(start_rec), 32'd0);
        tra_busy = 1'b0;
        tick();
        check("holdoff_sel", 32'(can_rec_select), 32'd7);
        check("holdoff_start", 32'(start_rec), 32'd1);
        // tra_busy during an active grant does not abort it
        tra_busy = 1'b1;
        tick();
        end_can_proc = 1'b1;
        tick();
        end_can_proc = 1'b0;
        tra_busy = 1'b0;
        irq_can_rec = '0;
        check("holdoff_cnt", 32'(grant_cnt), 32'd5);
        tick();

        // Watchdog on bus 9; bus 10 also requests
        irq_can_rec[9] = 1'b1;
        tick();
        check("wd_sel", 32'(can_rec_select), 32'd9);
        irq_can_rec[10] = 1'b1;
        irq_can_rec[9]  = 1'b0;   // drop on granted bus is ignored
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("wd_early", 32'(timeout_err), 32'd0);
        end
        check("wd_still_busy", 32'(rec_busy), 32'd1);
        tick();
        check("wd_tmo", 32'(timeout_err), 32'd1);
        check("wd_errbus", 32'(err_bus), 32'd9);
        check("wd_cnt", 32'(grant_cnt), 32'd5);
        tick();
        check("wd_tmo_pulse", 32'(timeout_err), 32'd0);
        tick();
        check("wd_next_sel", 32'(can_rec_select), 32'd10);

        // Collision: end_can_proc on the watchdog cycle
        irq_can_rec = '0;
        for (int i = 1; i <= 16; i++) begin
            tick();
        end
        end_can_proc = 1'b1;
        tick();
        end_can_proc = 1'b0;
        check("coll_tmo", 32'(timeout_err), 32'd0);
        check("coll_cnt", 32'(grant_cnt), 32'd6);
        check("coll_errbus", 32'(err_bus), 32'd9);
        tick();

        // Reset in WAIT_DONE with select 12
        irq_can_rec[12] = 1'b1;
        tick();
        check("rstmid_sel", 32'(can_rec_select), 32'd12);
        tick();
        tick();
        irq_can_rec[2] = 1'b1;
        rst = 1'b0;
        #2;
        check("rstmid_async_sel", 32'(can_rec_select), 32'd0);
        check("rstmid_async_busy", 32'(rec_busy), 32'd0);
        check("rstmid_async_cnt", 32'(grant_cnt), 32'd0);
        check("rstmid_async_errbus", 32'(err_bus), 32'd0);
        tick();
        rst = 1'b1;
        check("rstrel_start", 32'(start_rec), 32'd0);
        check("rstrel_tmo", 32'(timeout_err), 32'd0);
        tick();
        check("rstrel_sel", 32'(can_rec_select), 32'd2);
        check("rstrel_start_pulse", 32'(start_rec), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
